// File: rtl/ksa_blocking.sv
// Kahan compensated single-precision accumulator built around one shared FP adder.
// Define KAHAN_COMP_EN for the compensated sequence; without it the block does plain summation.
module ksa_blocking (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_en,
  input  logic [31:0] fp_input,
  output logic [31:0] inty,
  output logic [31:0] intc,
  output logic [31:0] intt,
  output logic        av1, av2, av3, av4,
  output logic        bv1, bv2, bv3, bv4,
  output logic        ar1, ar2, ar3, ar4,
  output logic        br1, br2, br3, br4,
  output logic        rv1, rv2, rv3, rv4,
  output logic        rr1, rr2, rr3, rr4,
  output logic [31:0] y,
  output logic [31:0] t,
  output logic [31:0] c,
  output logic [4:0]  state,
  output logic [31:0] sum
);

  localparam logic [4:0] ST_IDLE   = 5'd0;
  localparam logic [4:0] ST_UPDATE = 5'd17;
  localparam logic [4:0] ST_OP2_RES = 5'd8;

  typedef enum logic [1:0] {PH_SEND, PH_ACK, PH_EXEC, PH_RES} phase_e;

  logic [4:0]  state_q, state_d;
  logic [3:0]  seq_m1;
  logic [1:0]  op_idx;
  phase_e      phase;
  logic        in_op;
  logic [3:0]  av_v, bv_v, ar_v, br_v, rv_v, rr_v;
  logic [31:0] inty_q, intc_q, intt_q, y_q, t_q, c_q, sum_q;
  logic [31:0] opa_q, opb_q, res_q;
  logic [31:0] op_a, op_b, add_res;
  logic        op_sub;

  // Each op owns four consecutive codes starting at 1; decode op number and phase from them.
  assign in_op  = (state_q != ST_IDLE) && (state_q != ST_UPDATE);
  assign seq_m1 = 4'(state_q - 5'd1);
  assign op_idx = seq_m1[3:2];
  assign phase  = phase_e'(seq_m1[1:0]);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) begin
      if (write_en) state_d = 5'd1;
    end else if (state_q == ST_UPDATE) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_q + 5'd1;
`ifndef KAHAN_COMP_EN
      if (state_q == ST_OP2_RES) state_d = ST_UPDATE;
`endif
    end
  end

  always_comb begin
    av_v = '0; bv_v = '0; ar_v = '0; br_v = '0; rv_v = '0; rr_v = '0;
    if (in_op) begin
      case (phase)
        PH_SEND: begin av_v[op_idx] = 1'b1; bv_v[op_idx] = 1'b1; end
        PH_ACK:  begin ar_v[op_idx] = 1'b1; br_v[op_idx] = 1'b1; end
        PH_RES:  begin rv_v[op_idx] = 1'b1; rr_v[op_idx] = 1'b1; end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (op_idx)
      2'd0:    begin op_a = inty_q; op_b = intc_q; op_sub = 1'b1; end
      2'd1:    begin op_a = sum_q;  op_b = y_q;    op_sub = 1'b0; end
      2'd2:    begin op_a = t_q;    op_b = sum_q;  op_sub = 1'b1; end
      default: begin op_a = intt_q; op_b = y_q;    op_sub = 1'b1; end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inty_q <= '0; intc_q <= '0; intt_q <= '0; y_q <= '0; t_q <= '0; c_q <= '0;
      sum_q  <= '0; opa_q  <= '0; opb_q  <= '0; res_q <= '0;
    end else begin
      if (state_q == ST_IDLE && write_en) begin
        inty_q <= fp_input;
        intc_q <= c_q;
      end
      if (in_op) begin
        case (phase)
          PH_ACK: begin
            opa_q <= op_a;
            opb_q <= {op_b[31] ^ op_sub, op_b[30:0]};
          end
          PH_EXEC: res_q <= add_res;
          PH_RES: begin
            case (op_idx)
              2'd0:    y_q    <= res_q;
              2'd1:    t_q    <= res_q;
              2'd2:    intt_q <= res_q;
              default: c_q    <= res_q;
            endcase
          end
          default: ;
        endcase
      end
      if (state_q == ST_UPDATE) sum_q <= t_q;
    end
  end

  logic        a_s, b_s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap, big_s, rnd_up;
  logic [7:0]  a_e, b_e, big_e, sml_e, e_diff;
  logic [22:0] a_m, b_m, res_f;
  logic [26:0] big_m, sml_m, sml_al, norm;
  logic [27:0] raw;
  logic [4:0]  lz;
  logic signed [9:0] res_e;
  logic [24:0] mant_r;

  // Shared adder: opb_q already carries the inverted sign for subtractions.
  // NOTE: every variable gets a value on every path through this block, so no latch is inferred.
  always_comb begin
    {a_s, a_e, a_m} = opa_q;
    {b_s, b_e, b_m} = opb_q;
    a_nan  = (a_e == 8'hFF) && (a_m != '0);
    b_nan  = (b_e == 8'hFF) && (b_m != '0);
    a_inf  = (a_e == 8'hFF) && (a_m == '0);
    b_inf  = (b_e == 8'hFF) && (b_m == '0);
    a_zero = (a_e == 8'h00);
    b_zero = (b_e == 8'h00);
    swap   = {b_e, b_m} > {a_e, a_m};
    big_s  = swap ? b_s : a_s;
    big_e  = swap ? b_e : a_e;
    sml_e  = swap ? a_e : b_e;
    big_m  = {1'b1, swap ? b_m : a_m, 3'b000};
    sml_m  = {1'b1, swap ? a_m : b_m, 3'b000};
    e_diff = big_e - sml_e;
    // Bits shifted past the sticky position are folded into its LSB.
    if (e_diff >= 8'd27) begin
      sml_al = 27'd1;
    end else begin
      sml_al    = sml_m >> e_diff;
      sml_al[0] = sml_al[0] | (|(sml_m & ~({27{1'b1}} << e_diff)));
    end
    raw = (a_s == b_s) ? ({1'b0, big_m} + {1'b0, sml_al}) : ({1'b0, big_m} - {1'b0, sml_al});
    lz = '0;
    for (int i = 0; i <= 26; i++) begin
      if (raw[i]) lz = 5'(26 - i);
    end
    if (raw[27]) begin
      norm  = {raw[27:2], raw[1] | raw[0]};
      res_e = $signed({2'b00, big_e}) + 10'sd1;
    end else begin
      norm  = raw[26:0] << lz;
      res_e = $signed({2'b00, big_e}) - $signed({5'd0, lz});
    end
    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r = {1'b0, norm[26:3]} + {24'd0, rnd_up};
    if (mant_r[24]) res_e = res_e + 10'sd1;
    res_f = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

    if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) add_res = 32'h7FC0_0000;
    else if (a_inf)              add_res = {a_s, 8'hFF, 23'd0};
    else if (b_inf)              add_res = {b_s, 8'hFF, 23'd0};
    else if (a_zero && b_zero)   add_res = {a_s & b_s, 31'd0};
    else if (a_zero)             add_res = opb_q;
    else if (b_zero)             add_res = opa_q;
    else if (raw == '0)          add_res = '0;
    else if (res_e >= 10'sd255)  add_res = {big_s, 8'hFF, 23'd0};
    else if (res_e < 10'sd1)     add_res = {big_s, 31'd0};
    else                         add_res = {big_s, res_e[7:0], res_f};
  end

  assign {av4, av3, av2, av1} = av_v;
  assign {bv4, bv3, bv2, bv1} = bv_v;
  assign {ar4, ar3, ar2, ar1} = ar_v;
  assign {br4, br3, br2, br1} = br_v;
  assign {rv4, rv3, rv2, rv1} = rv_v;
  assign {rr4, rr3, rr2, rr1} = rr_v;
  assign inty  = inty_q;
  assign intc  = intc_q;
  assign intt  = intt_q;
  assign y     = y_q;
  assign t     = t_q;
  assign c     = c_q;
  assign state = state_q;
  assign sum   = sum_q;

endmodule

// File: tb/tb_ksa_blocking.sv
// Bench for ksa_blocking: directed and random element writes checked against an exact-integer FP model.
module tb_ksa_blocking;

`ifdef KAHAN_COMP_EN
  localparam bit KAHAN = 1'b1;
  localparam int LAT   = 17;
`else
  localparam bit KAHAN = 1'b0;
  localparam int LAT   = 9;
`endif
  localparam int PERIOD = LAT + 1;

  logic        clock, reset, write_en;
  logic [31:0] fp_input;
  logic [31:0] inty, intc, intt, y, t, c, sum;
  logic        av1, av2, av3, av4, bv1, bv2, bv3, bv4, ar1, ar2, ar3, ar4;
  logic        br1, br2, br3, br4, rv1, rv2, rv3, rv4, rr1, rr2, rr3, rr4;
  logic [4:0]  state;
  logic [23:0] hs;
  logic [252:0] all_outs;

  int checks, errors;
  logic [31:0] m_sum, m_c, m_y, m_t, m_d, m_intc;

  ksa_blocking dut (
    .clock(clock), .reset(reset), .write_en(write_en), .fp_input(fp_input),
    .inty(inty), .intc(intc), .intt(intt),
    .av1(av1), .av2(av2), .av3(av3), .av4(av4),
    .bv1(bv1), .bv2(bv2), .bv3(bv3), .bv4(bv4),
    .ar1(ar1), .ar2(ar2), .ar3(ar3), .ar4(ar4),
    .br1(br1), .br2(br2), .br3(br3), .br4(br4),
    .rv1(rv1), .rv2(rv2), .rv3(rv3), .rv4(rv4),
    .rr1(rr1), .rr2(rr2), .rr3(rr3), .rr4(rr4),
    .y(y), .t(t), .c(c), .state(state), .sum(sum)
  );

  assign hs = {av4, av3, av2, av1, bv4, bv3, bv2, bv1, ar4, ar3, ar2, ar1,
               br4, br3, br2, br1, rv4, rv3, rv2, rv1, rr4, rr3, rr2, rr1};
  assign all_outs = {inty, intc, intt, y, t, c, state, sum, hs};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Exact sum as an integer in units of 2^-149, then round-to-nearest-even to 24 bits.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b_in, input bit sub);
    logic [31:0]  b;
    logic [299:0] na, nb, n, rem, half;
    logic [24:0]  m;
    int ea, eb, p, e, sh;
    bit s;
    b  = {b_in[31] ^ sub, b_in[30:0]};
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC0_0000;
    if (ea == 255 && eb == 255) return (a[31] == b[31]) ? a : 32'h7FC0_0000;
    if (ea == 255) return a;
    if (eb == 255) return b;
    if (ea == 0 && eb == 0) return {a[31] & b[31], 31'd0};
    if (ea == 0) return b;
    if (eb == 0) return a;
    na = 300'({1'b1, a[22:0]}) << (ea - 1);
    nb = 300'({1'b1, b[22:0]}) << (eb - 1);
    if (a[31] == b[31])  begin n = na + nb; s = a[31]; end
    else if (na >= nb)   begin n = na - nb; s = a[31]; end
    else                 begin n = nb - na; s = b[31]; end
    if (n == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 300; i++) if (n[i]) p = i;
    if (p < 23) return {s, 31'd0};
    e  = p - 22;
    sh = p - 23;
    m  = 25'(n >> sh);
    if (sh > 0) begin
      rem  = n & ((300'd1 << sh) - 300'd1);
      half = 300'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 25'd1;
    end
    if (m[24]) begin m = m >> 1; e = e + 1; end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    return {s, 8'(e), m[22:0]};
  endfunction

  function automatic int next_state(input int s);
    if (s == 17) return 0;
    if (!KAHAN && s == 8) return 17;
    return s + 1;
  endfunction

  function automatic logic [23:0] hs_expect(input int s);
    logic [3:0] av, bv, ar, br, rv, rr;
    int k;
    av = '0; bv = '0; ar = '0; br = '0; rv = '0; rr = '0;
    if (s >= 1 && s <= 16) begin
      k = (s - 1) / 4;
      case ((s - 1) % 4)
        0: begin av[k] = 1'b1; bv[k] = 1'b1; end
        1: begin ar[k] = 1'b1; br[k] = 1'b1; end
        3: begin rv[k] = 1'b1; rr[k] = 1'b1; end
        default: ;
      endcase
    end
    return {av, bv, ar, br, rv, rr};
  endfunction

  function automatic logic [31:0] hold_val(input int j);
    return {1'b0, 8'(126 + j % 5), 23'(j * 40503)};
  endfunction

  task automatic model_reset();
    m_sum = '0; m_c = '0; m_y = '0; m_t = '0; m_d = '0; m_intc = '0;
  endtask

  task automatic model_iter(input logic [31:0] x);
    m_intc = m_c;
    m_y    = ref_add(x, m_c, 1'b1);
    m_t    = ref_add(m_sum, m_y, 1'b0);
    if (KAHAN) begin
      m_d = ref_add(m_t, m_sum, 1'b1);
      m_c = ref_add(m_d, m_y, 1'b1);
    end
    m_sum = m_t;
  endtask

  task automatic check_results(input logic [31:0] x);
    check("inty", inty, x);
    check("intc", intc, m_intc);
    check("y", y, m_y);
    check("t", t, m_t);
    check("intt", intt, m_d);
    check("c", c, m_c);
    check("sum", sum, m_sum);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  // One element write with a per-cycle state/handshake sweep and a stray write_en pulse.
  task automatic do_write(input logic [31:0] x);
    int n, exp_s;
    @(negedge clock);
    write_en = 1'b1;
    fp_input = x;
    @(negedge clock);
    write_en = 1'b0;
    fp_input = $urandom;
    n = 0;
    exp_s = 1;
    while (state != 5'd0 && n < 40) begin
      check("state_seq", state, exp_s);
      check("handshake", hs, hs_expect(exp_s));
      exp_s = next_state(exp_s);
      write_en = (n == 5);
      @(negedge clock);
      n++;
    end
    write_en = 1'b0;
    check("latency", n, LAT);
    check("idle_strobes", hs, 24'd0);
    model_iter(x);
    check_results(x);
  endtask

  initial begin
    int n, acc, prev;
    logic [31:0] r, x;
    checks = 0;
    errors = 0;
    reset = 1'b0;
    write_en = 1'b0;
    fp_input = '0;
    model_reset();
    #12;
    check("reset_outputs", all_outs, 253'd0);
    @(negedge clock);
    reset = 1'b1;

    do_write(32'h3F80_0000);
    check("sum_one", sum, 32'h3F80_0000);
    check("c_one", c, 32'h0);
    do_write(32'h4000_0000);
    check("sum_three", sum, 32'h4040_0000);

    // Asynchronous abort mid-iteration.
    @(negedge clock);
    write_en = 1'b1;
    fp_input = 32'h40A0_0000;
    @(negedge clock);
    write_en = 1'b0;
    n = 0;
    while (state != 5'd6 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("reach_state6", state, 5'd6);
    #2 reset = 1'b0;
    #1 check("async_reset", all_outs, 253'd0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    do_write(32'h3F80_0000);
    check("sum_after_abort", sum, 32'h3F80_0000);

    // Compensation around 2^24.
    apply_reset();
    do_write(32'h4B80_0000);
    check("sum_2p24", sum, 32'h4B80_0000);
    do_write(32'h3F80_0000);
`ifdef KAHAN_COMP_EN
    check("t_2p24", t, 32'h4B80_0000);
    check("c_minus1", c, 32'hBF80_0000);
`endif
    check("sum_2p24_tie", sum, 32'h4B80_0000);
    do_write(32'h3F80_0000);
`ifdef KAHAN_COMP_EN
    check("y_two", y, 32'h4000_0000);
    check("sum_comp", sum, 32'h4B80_0001);
    check("c_zero", c, 32'h0);
`else
    check("sum_naive", sum, 32'h4B80_0000);
`endif

    // Special values.
    apply_reset();
    do_write(32'h7F80_0000);
    check("sum_pinf", sum, 32'h7F80_0000);
    do_write(32'hFF80_0000);
    check("sum_nan", sum, 32'h7FC0_0000);
    apply_reset();
    do_write(32'h7F7F_FFFF);
    do_write(32'h7F7F_FFFF);
    check("sum_overflow", sum, 32'h7F80_0000);

    // write_en held high: one acceptance per iteration.
    apply_reset();
    acc = 0;
    prev = 0;
    @(negedge clock);
    write_en = 1'b1;
    fp_input = hold_val(0);
    for (int j = 1; j < 3 * PERIOD; j++) begin
      @(negedge clock);
      if (prev == 0 && state == 5'd1) acc++;
      prev = int'(state);
      fp_input = hold_val(j);
    end
    @(negedge clock);
    if (prev == 0 && state == 5'd1) acc++;
    write_en = 1'b0;
    check("hold_idle", state, 5'd0);
    check("hold_accepts", acc, 3);
    model_iter(hold_val(0));
    model_iter(hold_val(PERIOD));
    model_iter(hold_val(2 * PERIOD));
    check("hold_inty", inty, hold_val(2 * PERIOD));
    check("hold_c", c, m_c);
    check("hold_sum", sum, m_sum);

    // Random elements near a common magnitude, with occasional zero/denormal operands.
    apply_reset();
    for (int i = 0; i < 30; i++) begin
      r = $urandom;
      x = {r[31], (r[26:24] == 3'd0) ? 8'd0 : 8'($urandom_range(136, 118)), r[22:0]};
      do_write(x);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
